regfile_param: RTL and testbench
================================

# regfile_param

Parametrised, instruction-driven register file for the microcoded processor datapath. It holds DEPTH registers of WIDTH bits and talks to the rest of the datapath through the shared tri-state data bus. It executes one register-file micro-op per accepted instruction, including a two-cycle paired read that feeds both ALU operands onto the bus back-to-back. It replaces the fixed A/B/OP register arrangement with an addressable array.

## Interface
- WIDTH, 4: register and bus width in bits.
- DEPTH, 4: number of registers; power of two, at least 2.
- AW, $clog2(DEPTH): register index width (derived, not overridden).
- clk  input  1  clock; all state updates on the rising edge.
- grst  input  1  global reset; asynchronous, active-low.
- instr_valid  input  1  instruction present on `instr`.
- instr_ready  output  1  block can accept an instruction this cycle.
- instr  input  3+2*AW  packed as {op[2:0], rd[AW-1:0], rs[AW-1:0]}.
- imm  input  WIDTH  immediate operand for LDI.
- bus  inout  WIDTH  shared data bus; high-Z unless this block is reading out.
- busy  output  1  high while a multi-cycle op is in progress (equals ~instr_ready).

## Operation
- An instruction is accepted when instr_valid && instr_ready. All register writes take effect at the accept edge.
- Opcodes:
  - 000 NOP: no effect.
  - 001 LDI: R[rd] <= imm.
  - 010 RD: drive R[rs] on `bus` during the accept cycle.
  - 011 WR: R[rd] <= bus, sampled at the accept edge.
  - 100 MOV: R[rd] <= R[rs].
  - 101 RDP: paired read. Drive R[rs] in the accept cycle, then R[rd] in the next cycle.
  - 110 CLR: all registers <= 0.
  - 111 INC: R[rd] <= R[rs] + 1, truncated to WIDTH bits (wraps from all-ones to 0, no carry out).
- rd == rs is legal for every op. MOV is then a no-op; INC increments in place; RDP drives the same value twice.
- FSM has two states:
  - IDLE: instr_ready = 1. An accepted RDP moves to PAIR2 and latches rd into an internal pointer. Every other op stays in IDLE.
  - PAIR2: instr_ready = 0. Drives R[latched rd] on `bus` and ignores instr_valid. Returns to IDLE on the next edge.
- Register contents read in PAIR2 are the current values. No write can occur in PAIR2.
- `bus` drive enable is combinational from the accepted op and the FSM state. In any cycle with neither RD, RDP accept, nor PAIR2, the bus is high-Z.

## Timing
- Reset (grst low, asynchronous):
  - all registers = 0, FSM = IDLE, latched pointer = 0.
  - instr_ready = 1, busy = 0, bus = high-Z immediately.
- Reset mid-RDP (during PAIR2): the second read is abandoned and the bus is released in the same cycle grst falls.
- Write latency is 1 cycle: a value written at edge N is visible to RD/MOV/INC accepted in cycle N+1.
- Read latency is 0: RD data is valid on `bus` in the accept cycle, combinationally from the register.
- RDP occupies exactly 2 cycles. The next instruction can be accepted in the cycle after PAIR2.
- Throughput: 1 instruction/cycle for all ops except RDP (1 per 2 cycles).

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - R0 is hard-wired to zero. It reads 0 on RD/RDP/MOV/INC sources.
  - Writes to R0 (LDI, WR, MOV, INC, CLR) are discarded.
  - No storage is built for R0.
- REGFILE_ZERO_REG_EN undefined: R0 is an ordinary register.

## Test plan
- Reset/LDI/RD: grst low, release. Then LDI R2 imm=4'hA, then RD rs=2 -> bus=4'hA in the RD cycle, high-Z in all other cycles.
- WR/MOV/INC wrap: drive bus=4'h7 with WR R1, then MOV R3<-R1, then INC R3<-R3 three times, then LDI R0 4'hF and INC R0<-R0.
  - R3 reads 4'hA.
  - R0 reads 4'h0 after the wrap (macro off).
- RDP handshake: R1=4'h3, R2=4'h5, then RDP rs=1 rd=2 with instr_valid held high.
  - bus = 3 then 5.
  - instr_ready = 0 in the second cycle.
  - The held instruction is not re-executed until the third cycle.
- Reset mid-RDP: assert grst asynchronously during PAIR2.
  - bus goes high-Z immediately.
  - instr_ready = 1.
  - All registers = 0.
- CLR and back-to-back hazard: LDI R1=9 followed directly by RD rs=1 -> bus=9. Then CLR, then RD on each register -> 0.
- Zero-register (REGFILE_ZERO_REG_EN defined): LDI R0 4'hC, then RD rs=0 -> bus=0. Also MOV R1<-R0 -> R1=0.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: addressable register file driven by one micro-op per accepted
// instruction, sharing a tri-state data bus with the rest of the datapath.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   grst         asynchronous active-low reset
//   instr_valid  instruction present on instr
//   instr_ready  block can accept an instruction this cycle
//   instr        {op[2:0], rd[AW-1:0], rs[AW-1:0]}
//   imm          immediate operand for LDI
//   bus          shared data bus, high-Z unless this block is reading out
//   busy         high while the second half of a paired read is in progress
//
// Build option: define REGFILE_ZERO_REG_EN to hard-wire R0 to zero (no storage
// is built for it and writes to it are discarded).
module regfile_param #(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned IW    = 3 + 2 * AW
) (
    input  logic             clk,
    input  logic             grst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [IW-1:0]    instr,
    input  logic [WIDTH-1:0] imm,
    inout  wire  [WIDTH-1:0] bus,
    output logic             busy
);

`ifdef REGFILE_ZERO_REG_EN
    localparam int unsigned FIRST = 1;
`else
    localparam int unsigned FIRST = 0;
`endif

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_RD  = 3'b010;
    localparam logic [2:0] OP_WR  = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_RDP = 3'b101;
    localparam logic [2:0] OP_CLR = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        PAIR2 = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] regs    [FIRST:DEPTH-1];
    logic [WIDTH-1:0] rf_view [DEPTH];

    logic [2:0]       op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs;
    logic             accept;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             clr;
    logic             drv_en;
    logic [WIDTH-1:0] drv_data;

    assign op     = instr[IW-1 -: 3];
    assign rd     = instr[2*AW-1 -: AW];
    assign rs     = instr[AW-1:0];
    assign accept = instr_valid && instr_ready;

    // Read view of the array; R0 reads zero when it has no storage.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rf_view[i] = '0;
        end
        for (int unsigned i = FIRST; i < DEPTH; i++) begin
            rf_view[i] = regs[i];
        end
    end

    // Micro-op decode: write port, clear and bus drive selection.
    always_comb begin
        wr_en    = 1'b0;
        wr_data  = '0;
        clr      = 1'b0;
        drv_en   = 1'b0;
        drv_data = '0;
        if (state == PAIR2) begin
            drv_en   = 1'b1;
            drv_data = rf_view[ptr];
        end else if (accept) begin
            case (op)
                OP_LDI: begin
                    wr_en   = 1'b1;
                    wr_data = imm;
                end
                OP_RD, OP_RDP: begin
                    drv_en   = 1'b1;
                    drv_data = rf_view[rs];
                end
                OP_WR: begin
                    wr_en   = 1'b1;
                    wr_data = bus;
                end
                OP_MOV: begin
                    wr_en   = 1'b1;
                    wr_data = rf_view[rs];
                end
                OP_CLR: clr = 1'b1;
                OP_INC: begin
                    wr_en   = 1'b1;
                    wr_data = rf_view[rs] + WIDTH'(1);
                end
                OP_NOP:  ;
                default: ;
            endcase
        end
    end

    // Gating with grst releases the bus the moment reset asserts.
    assign bus = (drv_en && grst) ? drv_data : {WIDTH{1'bz}};

    // Paired-read sequencer with registered handshake outputs.
    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            state       <= IDLE;
            ptr         <= '0;
            instr_ready <= 1'b1;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && op == OP_RDP) begin
                        state       <= PAIR2;
                        ptr         <= rd;
                        instr_ready <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                PAIR2: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Register array; writes only happen on an accept edge in IDLE.
    always_ff @(posedge clk or negedge grst) begin
        if (!grst) begin
            for (int unsigned i = FIRST; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = FIRST; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = FIRST; i < DEPTH; i++) begin
                if (rd == AW'(i)) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed checks of regfile_param (WIDTH=4, DEPTH=4).
// The bus is a pulled-up net, so a released bus reads 4'hF.
module tb_regfile_param;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_RD  = 3'b010;
    localparam logic [2:0] OP_WR  = 3'b011;
    localparam logic [2:0] OP_MOV = 3'b100;
    localparam logic [2:0] OP_RDP = 3'b101;
    localparam logic [2:0] OP_CLR = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;
    localparam logic [3:0] HIZ    = 4'hF;

    logic       clk = 1'b0;
    logic       grst;
    logic       instr_valid;
    logic       instr_ready;
    logic [6:0] instr;
    logic [3:0] imm;
    logic       busy;
    logic       tb_drv;
    logic [3:0] tb_val;
    tri1  [3:0] bus;

    int n_checks = 0;
    int n_fail   = 0;

    assign bus = tb_drv ? tb_val : 4'bzzzz;

    always #5 clk = ~clk;

    regfile_param dut (
        .clk         (clk),
        .grst        (grst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .imm         (imm),
        .bus         (bus),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an instruction for one cycle; returns mid-cycle, before the accept edge.
    task automatic step(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                        input logic [3:0] iv);
        @(negedge clk);
        instr_valid = 1'b1;
        instr       = {op, rd, rs};
        imm         = iv;
        #2;
    endtask

    task automatic idle();
        @(negedge clk);
        instr_valid = 1'b0;
        #2;
    endtask

    initial begin
        grst        = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        imm         = '0;
        tb_drv      = 1'b0;
        tb_val      = '0;
        #13;
        check("reset_ready", {3'b0, instr_ready}, 4'h1);
        check("reset_busy", {3'b0, busy}, 4'h0);
        check("reset_bus", bus, HIZ);
        @(negedge clk);
        grst = 1'b1;

        // Reset / LDI / RD
        step(OP_LDI, 2'd2, 2'd0, 4'hA);
        check("ldi_bus_hiz", bus, HIZ);
        step(OP_RD, 2'd0, 2'd2, 4'h0);
        check("rd_r2", bus, 4'hA);
        idle();
        check("idle_bus_hiz", bus, HIZ);

        // WR / MOV / INC wrap
        tb_drv = 1'b1;
        tb_val = 4'h7;
        step(OP_WR, 2'd1, 2'd0, 4'h0);
        check("wr_bus_tb", bus, 4'h7);
        step(OP_MOV, 2'd3, 2'd1, 4'h0);
        tb_drv = 1'b0;
        step(OP_INC, 2'd3, 2'd3, 4'h0);
        step(OP_INC, 2'd3, 2'd3, 4'h0);
        step(OP_INC, 2'd3, 2'd3, 4'h0);
        step(OP_RD, 2'd0, 2'd3, 4'h0);
        check("inc_r3", bus, 4'hA);
        step(OP_RD, 2'd0, 2'd1, 4'h0);
        check("wr_r1", bus, 4'h7);
        step(OP_LDI, 2'd0, 2'd0, 4'hF);
        step(OP_INC, 2'd0, 2'd0, 4'h0);
        step(OP_RD, 2'd0, 2'd0, 4'h0);
        check("inc_wrap_r0", bus, 4'h0);

        // RDP handshake with instr_valid held
        step(OP_LDI, 2'd1, 2'd0, 4'h3);
        step(OP_LDI, 2'd2, 2'd0, 4'h5);
        step(OP_RDP, 2'd2, 2'd1, 4'h0);
        check("rdp_first", bus, 4'h3);
        check("rdp_ready1", {3'b0, instr_ready}, 4'h1);
        @(negedge clk); #2;
        check("rdp_second", bus, 4'h5);
        check("rdp_ready2", {3'b0, instr_ready}, 4'h0);
        check("rdp_busy2", {3'b0, busy}, 4'h1);
        @(negedge clk); #2;
        check("rdp_reissue", bus, 4'h3);
        check("rdp_ready3", {3'b0, instr_ready}, 4'h1);

        // Reset during PAIR2
        @(negedge clk); #2;
        check("pair2_before_rst", bus, 4'h5);
        grst = 1'b0;
        #1;
        check("rst_mid_bus", bus, HIZ);
        check("rst_mid_ready", {3'b0, instr_ready}, 4'h1);
        check("rst_mid_busy", {3'b0, busy}, 4'h0);
        instr_valid = 1'b0;
        @(negedge clk);
        grst = 1'b1;
        step(OP_RD, 2'd0, 2'd1, 4'h0);
        check("rst_r1", bus, 4'h0);
        step(OP_RD, 2'd0, 2'd2, 4'h0);
        check("rst_r2", bus, 4'h0);
        step(OP_RD, 2'd0, 2'd3, 4'h0);
        check("rst_r3", bus, 4'h0);

        // Back-to-back hazard, then CLR
        step(OP_LDI, 2'd1, 2'd0, 4'h9);
        step(OP_RD, 2'd0, 2'd1, 4'h0);
        check("b2b_r1", bus, 4'h9);
        step(OP_LDI, 2'd3, 2'd0, 4'h6);
        step(OP_CLR, 2'd0, 2'd0, 4'h0);
        check("clr_bus_hiz", bus, HIZ);
        for (int i = 0; i < 4; i++) begin
            step(OP_RD, 2'd0, 2'(i), 4'h0);
            check($sformatf("clr_r%0d", i), bus, 4'h0);
        end

        // R0 behaviour depends on the build option
        step(OP_LDI, 2'd0, 2'd0, 4'hC);
        step(OP_RD, 2'd0, 2'd0, 4'h0);
`ifdef REGFILE_ZERO_REG_EN
        check("zero_r0", bus, 4'h0);
        step(OP_MOV, 2'd1, 2'd0, 4'h0);
        step(OP_RD, 2'd0, 2'd1, 4'h0);
        check("zero_mov_r1", bus, 4'h0);
`else
        check("plain_r0", bus, 4'hC);
        step(OP_MOV, 2'd1, 2'd0, 4'h0);
        step(OP_RD, 2'd0, 2'd1, 4'h0);
        check("plain_mov_r1", bus, 4'hC);
`endif
        step(OP_NOP, 2'd1, 2'd1, 4'h0);
        check("nop_bus_hiz", bus, HIZ);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
